control_multiciclo: RTL and testbench
=====================================

Name: control_multiciclo

Overview:
Moore-style multicycle control FSM that sequences a shared RV32I datapath: one ALU, one unified instruction/data memory port and one register file, reused across FETCH/DECODE/EXECUTE/MEM/WB steps. It sits beside the datapath in the multicycle core. It drives every mux select and write enable, handshakes with the memory port, flags illegal opcodes, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
zero  in  1  ALU zero flag (rs1 - rs2 == 0)
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  load PC from ALU result / ALUout
ir_write  out  1  load IR and oldPC
reg_write  out  1  register-file write enable
mem_read  out  1  memory read request
mem_write  out  1  memory write request
adr_src  out  1  memory address: 0=PC, 1=ALUout
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
result_src  out  2  00=ALUout, 01=mem data, 10=ALU result
alu_ctrl  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000
instr_done  out  1  one-cycle pulse on an instruction's final cycle
illegal_instr  out  1  sticky; unsupported opcode/funct3 decoded
retired  out  CNT_W  retired-instruction count
state  out  4  current state (debug)

Behaviour:
- Reset: state<=FETCH on the edge with reset=1. While reset=1, all control outputs=0, retired=0 and illegal_instr=0. Reset mid-instruction aborts it with no writes.
- FETCH: mem_read=1, adr_src=0, src_a=00, src_b=10, ADD. Hold while mem_ready=0. On mem_ready=1: ir_write=1, pc_write=1 (PC+4), then go to DECODE.
- DECODE: src_a=01, src_b=01, ADD (branch/jal target -> ALUout). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - otherwise -> ILLEGAL
- MEMADR: src_a=10, src_b=01, ADD. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_read=1, adr_src=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
- MEMWRITE: mem_write=1, adr_src=1. Hold until mem_ready; on that cycle instr_done=1, then FETCH.
- EXECR: src_a=10, src_b=00, alu_op=FUNC. EXECI: src_a=10, src_b=01, alu_op=FUNC. Both go to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, then FETCH.
- BRANCH: src_a=10, src_b=00, SUB, result_src=00, instr_done=1, then FETCH.
  - funct3 000: pc_write=zero.
  - funct3 001: pc_write=~zero.
  - Other funct3: ILLEGAL, no instr_done.
- JAL: src_a=01, src_b=10, ADD, result_src=10, reg_write=1 (rd=oldPC+4), pc_write=1 (ALUout target), instr_done=1, then FETCH.
- ILLEGAL: terminal until reset; all enables 0; illegal_instr=1, sticky.
- Latency with mem_ready always 1: lw 5 cycles; sw, R-type and I-type 4; branch and jal 3. Each extra mem_ready=0 cycle stretches FETCH, MEMREAD or MEMWRITE by one.
- mem_read/mem_write stay stable while waiting. mem_read and mem_write are never both 1.
- retired increments by 1 on every instr_done cycle and wraps from 2^CNT_W-1 to 0.
- alu_ctrl decode (FUNC), by funct3:
  - 000: SUB only if R-type and funct7_5=1, else ADD.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL.
  - 101: SRA if funct7_5=1, else SRL.
  - 011: SLT.

Decomposition:
- Package ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL
  - opcode constants
  - alu_ctrl codes
  - alu_op codes: ADD=00, SUB=01, FUNC=10
  - mux-select constants
- One sub-module, alu_decoder (combinational): inputs alu_op, funct3, funct7_5, opcode[5]; output alu_ctrl.

Test Plan:
- Reset 3 cycles, release, mem_ready=1 -> cycle after release: state=FETCH, mem_read=1. retired=0 and illegal_instr=0 throughout reset.
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB. EXECR alu_ctrl=0001 only for sub (0x402081B3), else 0000. reg_write in ALUWB. instr_done once; retired=1.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> total 10 cycles. mem_read held stable. reg_write only in MEMWB with result_src=01.
- beq, zero=1 then zero=0 -> pc_write=1 then 0 in BRANCH. Each takes 3 cycles; retired +2.
- Opcode 0x7F -> ILLEGAL. illegal_instr stays 1, no enables for 20 cycles, retired frozen. Reset recovers to FETCH.
- Force retired to 2^CNT_W-1 (CNT_W=4: 15), complete one instruction -> retired=0. Reset asserted during MEMWRITE -> no further mem_write, state=FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op plus funct fields onto an ALU control code.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [3:0] alu_ctrl
);
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:  alu_ctrl = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alu_ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD; // addi ignores bit 30
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RV32I control FSM: sequences the shared datapath and counts retired instructions.
module control_multiciclo
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [3:0]       alu_ctrl,
  output logic             instr_done,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);
  state_t           st, nxt;
  logic [CNT_W-1:0] cnt;
  logic             pc_w, ir_w, reg_w, mrd, mwr, adr, done;
  logic [1:0]       src_a, src_b, res, alu_op;
  logic [3:0]       actl;

  alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .op5      (opcode[5]),
    .alu_ctrl (actl)
  );

  always_comb begin
    nxt = st;
    pc_w = 1'b0; ir_w = 1'b0; reg_w = 1'b0; mrd = 1'b0; mwr = 1'b0;
    adr = 1'b0; done = 1'b0;
    src_a = SRCA_PC; src_b = SRCB_RS2; res = RES_ALUOUT; alu_op = ALUOP_ADD;
    case (st)
      FETCH: begin
        mrd = 1'b1; src_b = SRCB_FOUR;
        if (mem_ready) begin ir_w = 1'b1; pc_w = 1'b1; nxt = DECODE; end
      end
      DECODE: begin
        src_a = SRCA_OLDPC; src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: nxt = MEMADR;
          OP_RTYPE:          nxt = EXECR;
          OP_ITYPE:          nxt = EXECI;
          OP_BRANCH:         nxt = BRANCH;
          OP_JAL:            nxt = JAL;
          default:           nxt = ILLEGAL;
        endcase
      end
      MEMADR: begin
        src_a = SRCA_RS1; src_b = SRCB_IMM;
        nxt = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mrd = 1'b1; adr = 1'b1;
        if (mem_ready) nxt = MEMWB;
      end
      MEMWB: begin
        res = RES_MEM; reg_w = 1'b1; done = 1'b1; nxt = FETCH;
      end
      MEMWRITE: begin
        mwr = 1'b1; adr = 1'b1;
        if (mem_ready) begin done = 1'b1; nxt = FETCH; end
      end
      EXECR: begin
        src_a = SRCA_RS1; src_b = SRCB_RS2; alu_op = ALUOP_FUNC; nxt = ALUWB;
      end
      EXECI: begin
        src_a = SRCA_RS1; src_b = SRCB_IMM; alu_op = ALUOP_FUNC; nxt = ALUWB;
      end
      ALUWB: begin
        res = RES_ALUOUT; reg_w = 1'b1; done = 1'b1; nxt = FETCH;
      end
      BRANCH: begin
        src_a = SRCA_RS1; src_b = SRCB_RS2; alu_op = ALUOP_SUB; res = RES_ALUOUT;
        case (funct3)
          3'b000:  begin pc_w = zero;  done = 1'b1; nxt = FETCH; end
          3'b001:  begin pc_w = ~zero; done = 1'b1; nxt = FETCH; end
          default: nxt = ILLEGAL;
        endcase
      end
      JAL: begin
        src_a = SRCA_OLDPC; src_b = SRCB_FOUR; res = RES_ALU;
        reg_w = 1'b1; pc_w = 1'b1; done = 1'b1; nxt = FETCH;
      end
      ILLEGAL: nxt = ILLEGAL;
      default: nxt = ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (done) cnt <= cnt + CNT_W'(1);
    end
  end

  // Reset masks every strobe in the same cycle so an aborted access never writes.
  assign pc_write      = pc_w  & ~reset;
  assign ir_write      = ir_w  & ~reset;
  assign reg_write     = reg_w & ~reset;
  assign mem_read      = mrd   & ~reset;
  assign mem_write     = mwr   & ~reset;
  assign adr_src       = adr   & ~reset;
  assign instr_done    = done  & ~reset;
  assign alu_src_a     = reset ? 2'b00 : src_a;
  assign alu_src_b     = reset ? 2'b00 : src_b;
  assign result_src    = reset ? 2'b00 : res;
  assign alu_ctrl      = reset ? 4'b0000 : actl;
  assign illegal_instr = (st == ILLEGAL) & ~reset;
  assign retired       = reset ? '0 : cnt;
  assign state         = st;
endmodule

// File: tb/tb_control_multiciclo.sv
// Directed-vector bench for control_multiciclo with a 4-bit retired counter.
module tb_control_multiciclo;
  import ctrl_pkg::*;

  logic       clk, reset, funct7_5, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_ctrl, retired, state;
  logic       instr_done, illegal_instr;

  int nvec = 0;
  int nerr = 0;
  int exp_ret = 0;

  control_multiciclo #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_ctrl(alu_ctrl), .instr_done(instr_done), .illegal_instr(illegal_instr),
    .retired(retired), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_instr(input logic [31:0] w);
    opcode = w[6:0]; funct3 = w[14:12]; funct7_5 = w[30];
  endtask

  // Advance one cycle; sample point is 1ns after the falling edge.
  task automatic cyc(input logic rdy);
    @(negedge clk); mem_ready = rdy; #1;
  endtask

  function automatic logic [31:0] en_bits();
    return {26'd0, pc_write, ir_write, reg_write, mem_read, mem_write, instr_done};
  endfunction

  state_t lw_st [10] = '{FETCH, FETCH, FETCH, DECODE, MEMADR,
                         MEMREAD, MEMREAD, MEMREAD, MEMREAD, MEMWB};

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    set_instr(32'h002081B3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_retired", 32'(retired), 0);
      chk("rst_illegal", 32'(illegal_instr), 0);
      chk("rst_enables", en_bits(), 0);
    end
    @(negedge clk); reset = 1'b0; #1;
    chk("rel_state", 32'(state), 32'(FETCH));
    chk("rel_mem_read", 32'(mem_read), 1);

    // add then sub
    for (int k = 0; k < 2; k++) begin
      set_instr(k ? 32'h402081B3 : 32'h002081B3); #1;
      chk("r_fetch_st", 32'(state), 32'(FETCH));
      chk("r_fetch_irpc", {ir_write, pc_write}, 2'b11);
      chk("r_fetch_srcb", 32'(alu_src_b), 2);
      cyc(1);
      chk("r_dec_st", 32'(state), 32'(DECODE));
      chk("r_dec_src", {alu_src_a, alu_src_b}, 4'b0101);
      cyc(1);
      chk("r_ex_st", 32'(state), 32'(EXECR));
      chk("r_ex_alu", 32'(alu_ctrl), k ? 1 : 0);
      chk("r_ex_src", {alu_src_a, alu_src_b}, 4'b1000);
      chk("r_ex_rw", 32'(reg_write), 0);
      cyc(1);
      chk("r_wb_st", 32'(state), 32'(ALUWB));
      chk("r_wb_rw_done", {reg_write, instr_done}, 2'b11);
      chk("r_wb_res", 32'(result_src), 0);
      cyc(1);
      exp_ret++;
      chk("r_retired", 32'(retired), 32'(exp_ret));
    end

    // lw with 2 FETCH stalls and 3 MEMREAD stalls: 10 cycles
    set_instr(32'h0000A183);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = !(i < 2 || (i >= 5 && i <= 7)); #1;
      chk("lw_state", 32'(state), 32'(lw_st[i]));
      chk("lw_mem_read", 32'(mem_read), (i < 3 || (i >= 5 && i <= 8)) ? 1 : 0);
      chk("lw_reg_write", 32'(reg_write), (i == 9) ? 1 : 0);
      chk("lw_done", 32'(instr_done), (i == 9) ? 1 : 0);
      if (i >= 5 && i <= 8) chk("lw_adr", 32'(adr_src), 1);
      if (i == 9) chk("lw_res", 32'(result_src), 1);
    end
    cyc(1);
    exp_ret++;
    chk("lw_retired", 32'(retired), 32'(exp_ret));

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      set_instr(32'h00208063); zero = z[0]; #1;
      chk("beq_fetch", 32'(state), 32'(FETCH));
      cyc(1);
      chk("beq_dec", 32'(state), 32'(DECODE));
      cyc(1);
      chk("beq_st", 32'(state), 32'(BRANCH));
      chk("beq_pcw", 32'(pc_write), 32'(z));
      chk("beq_alu", 32'(alu_ctrl), 1);
      chk("beq_done", 32'(instr_done), 1);
      cyc(1);
      exp_ret++;
      chk("beq_retired", 32'(retired), 32'(exp_ret));
    end

    // sw stalled in MEMWRITE, aborted by reset
    set_instr(32'h0020A023); #1;
    cyc(1);
    chk("sw_dec", 32'(state), 32'(DECODE));
    cyc(1);
    chk("sw_adr_st", 32'(state), 32'(MEMADR));
    chk("sw_adr_src", {alu_src_a, alu_src_b}, 4'b1001);
    cyc(0);
    chk("sw_st", 32'(state), 32'(MEMWRITE));
    chk("sw_rw", {mem_read, mem_write, adr_src, instr_done}, 4'b0110);
    cyc(0);
    chk("sw_hold", {mem_read, mem_write}, 2'b01);
    @(negedge clk); reset = 1'b1; #1;
    chk("sw_rst_mw", 32'(mem_write), 0);
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
    chk("sw_rst_st", 32'(state), 32'(FETCH));
    chk("sw_rst_mw2", 32'(mem_write), 0);
    chk("sw_rst_ret", 32'(retired), 0);
    exp_ret = 0;

    // 16 jal: counter walks up to 15 then wraps to 0
    set_instr(32'h0000006F);
    for (int j = 0; j < 16; j++) begin
      #1;
      chk("jal_fetch", 32'(state), 32'(FETCH));
      cyc(1);
      cyc(1);
      chk("jal_st", 32'(state), 32'(JAL));
      chk("jal_ctl", {reg_write, pc_write, instr_done, result_src, alu_src_a, alu_src_b},
          9'b111_10_01_10);
      cyc(1);
      exp_ret = (exp_ret + 1) % 16;
      chk("jal_retired", 32'(retired), 32'(exp_ret));
    end

    // illegal opcode: terminal until reset
    set_instr(32'h0000007F); #1;
    cyc(1);
    chk("ill_dec", 32'(state), 32'(DECODE));
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("ill_st", 32'(state), 32'(ILLEGAL));
      chk("ill_flag", 32'(illegal_instr), 1);
      chk("ill_en", en_bits(), 0);
      chk("ill_ret", 32'(retired), 32'(exp_ret));
    end
    @(negedge clk); reset = 1'b1; #1;
    chk("ill_rst_flag", 32'(illegal_instr), 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("ill_rec_st", 32'(state), 32'(FETCH));
    chk("ill_rec_flag", 32'(illegal_instr), 0);
    chk("ill_rec_mr", 32'(mem_read), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
